// File: rtl/line_raster_writer.sv
// line_raster_writer
// Rasterises line commands into a 320x240 back buffer using Bresenham's
// algorithm. Addresses are column-major (waddr = y + 240*x) and one pixel is
// written per clock. A frame_end request is held pending until the current
// line finishes. The buffer is then offered with done until swap is seen.
// Build option: define LINE_RASTER_CLEAR_EN to zero the whole back buffer
// after each swap, before new commands are accepted.
module line_raster_writer #(
    parameter int unsigned NUMBER_COLORS = 9,
    localparam int unsigned CW = $clog2(NUMBER_COLORS) + 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [8:0]    cmd_x0,
    input  logic [8:0]    cmd_x1,
    input  logic [7:0]    cmd_y0,
    input  logic [7:0]    cmd_y1,
    input  logic [CW-1:0] cmd_color,
    input  logic          frame_end,
    input  logic          swap,
    output logic          done,
    output logic [16:0]   waddr,
    output logic [CW-1:0] din,
    output logic          bb_we,
    output logic          busy
);

    localparam logic [8:0] ScreenW = 9'd320;
    localparam logic [7:0] ScreenH = 8'd240;
`ifdef LINE_RASTER_CLEAR_EN
    localparam logic [16:0] LastAddr = 17'd76799;
`endif

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StDraw  = 3'd2,
        StDone  = 3'd3
`ifdef LINE_RASTER_CLEAR_EN
        ,
        StClear = 3'd4
`endif
    } state_t;

    state_t state_q, state_d;
    logic   pend_q, pend_d;
    logic   run_q;

    // Current pixel, endpoint and colour of the line being drawn
    logic [8:0]    x_q, x1_q;
    logic [7:0]    y_q, y1_q;
    logic [CW-1:0] col_q;

    // Bresenham state; sx_q/sy_q set means step in the positive direction
    logic signed [10:0] dx_q, dy_q, err_q;
    logic               sx_q, sy_q;

`ifdef LINE_RASTER_CLEAR_EN
    logic [16:0] clr_q;
`endif

    logic               accept;
    logic               at_end;
    logic               in_bounds;
    logic [16:0]        pix_addr;
    logic signed [10:0] dx_raw, dy_raw, dx_abs, dy_abs;
    logic signed [11:0] e2, dx_w, dy_w;
    logic               step_x, step_y;
    logic signed [10:0] err_next;

    // Ready is withheld during reset, for one cycle after it, and whenever a
    // frame close is pending or being requested right now (frame_end wins).
    assign cmd_ready = run_q & ~reset & (state_q == StIdle) & ~pend_q & ~frame_end;
    assign accept    = cmd_valid & cmd_ready;

    assign at_end    = (x_q == x1_q) && (y_q == y1_q);
    assign in_bounds = (x_q < ScreenW) && (y_q < ScreenH);
    assign pix_addr  = {9'd0, y_q} + ({8'd0, x_q} * 17'd240);

    // SETUP operands: x_q/y_q still hold the start point here
    assign dx_raw = $signed({2'b00, x1_q}) - $signed({2'b00, x_q});
    assign dy_raw = $signed({3'b000, y1_q}) - $signed({3'b000, y_q});
    assign dx_abs = dx_raw[10] ? -dx_raw : dx_raw;
    assign dy_abs = dy_raw[10] ? -dy_raw : dy_raw;

    // e2 is one bit wider so 2*err cannot overflow
    assign e2       = {err_q, 1'b0};
    assign dx_w     = dx_q;
    assign dy_w     = dy_q;
    assign step_x   = (e2 >= dy_w);
    assign step_y   = (e2 <= dx_w);
    assign err_next = err_q + (step_x ? dy_q : 11'sd0) + (step_y ? dx_q : 11'sd0);

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pending-frame logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (state_q != StDone && frame_end) begin
            pend_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (pend_q || frame_end) begin
                    state_d = StDone;
                end else if (accept) begin
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StDraw;
            StDraw: begin
                if (at_end) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (swap) begin
                    pend_d = 1'b0;
`ifdef LINE_RASTER_CLEAR_EN
                    state_d = StClear;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef LINE_RASTER_CLEAR_EN
            StClear: begin
                if (clr_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bb_we = 1'b0;
        waddr = 17'd0;
        din   = '0;
        done  = 1'b0;
        busy  = (state_q != StIdle);
        case (state_q)
            StDraw: begin
                waddr = pix_addr;
                din   = col_q;
                bb_we = in_bounds;
            end
            StDone: done = 1'b1;
`ifdef LINE_RASTER_CLEAR_EN
            StClear: begin
                waddr = clr_q;
                bb_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Pending frame flag and post-reset ready qualifier
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            run_q  <= 1'b1;
        end
    end

    // Command latch, Bresenham setup and per-pixel stepping
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            x_q   <= 9'd0;
            x1_q  <= 9'd0;
            y_q   <= 8'd0;
            y1_q  <= 8'd0;
            col_q <= '0;
            dx_q  <= 11'sd0;
            dy_q  <= 11'sd0;
            err_q <= 11'sd0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        x_q   <= cmd_x0;
                        y_q   <= cmd_y0;
                        x1_q  <= cmd_x1;
                        y1_q  <= cmd_y1;
                        col_q <= cmd_color;
                    end
                end
                StSetup: begin
                    dx_q  <= dx_abs;
                    dy_q  <= -dy_abs;
                    err_q <= dx_abs - dy_abs;
                    sx_q  <= (x_q < x1_q);
                    sy_q  <= (y_q < y1_q);
                end
                StDraw: begin
                    if (!at_end) begin
                        err_q <= err_next;
                        if (step_x) begin
                            x_q <= sx_q ? x_q + 9'd1 : x_q - 9'd1;
                        end
                        if (step_y) begin
                            y_q <= sy_q ? y_q + 8'd1 : y_q - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LINE_RASTER_CLEAR_EN
    // Clear address counter, restarted every time CLEAR is entered
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clr_q <= 17'd0;
        end else if (state_q == StClear) begin
            clr_q <= clr_q + 17'd1;
        end else begin
            clr_q <= 17'd0;
        end
    end
`endif

endmodule

// File: tb/tb_line_raster_writer.sv
// Testbench for line_raster_writer: directed and random lines checked against
// a pixel-list reference model, plus frame hand-off and reset scenarios.
module tb_line_raster_writer;

    localparam int NCOL = 9;
    localparam int CW   = $clog2(NCOL) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [8:0]    cmd_x0 = '0, cmd_x1 = '0;
    logic [7:0]    cmd_y0 = '0, cmd_y1 = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          frame_end = 1'b0;
    logic          swap = 1'b0;
    logic          done;
    logic [16:0]   waddr;
    logic [CW-1:0] din;
    logic          bb_we;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_addr[$], wr_din[$], wr_edge[$];
    int ex_x[$], ex_y[$];

    line_raster_writer #(.NUMBER_COLORS(NCOL)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0   (cmd_x0),
        .cmd_x1   (cmd_x1),
        .cmd_y0   (cmd_y0),
        .cmd_y1   (cmd_y1),
        .cmd_color(cmd_color),
        .frame_end(frame_end),
        .swap     (swap),
        .done     (done),
        .waddr    (waddr),
        .din      (din),
        .bb_we    (bb_we),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: a write seen between edges k and k+1 commits at edge k+1
    always @(negedge clk) begin
        if (bb_we === 1'b1) begin
            wr_addr.push_back(int'(waddr));
            wr_din.push_back(int'(din));
            wr_edge.push_back(cyc + 1);
        end
    end

    task automatic clear_writes();
        wr_addr.delete();
        wr_din.delete();
        wr_edge.delete();
    endtask

    // Reference: full pixel list of a line, endpoints inclusive
    task automatic model_line(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        ex_x.delete();
        ex_y.delete();
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        forever begin
            ex_x.push_back(x);
            ex_y.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int col, output int acc, output bit ok);
        int g = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        ok        = (cmd_ready === 1'b1);
        cmd_x0    = x0[8:0];
        cmd_y0    = y0[7:0];
        cmd_x1    = x1[8:0];
        cmd_y1    = y1[7:0];
        cmd_color = col[CW-1:0];
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    // Draws one line; fe_at >= 0 pulses frame_end on that busy cycle
    task automatic run_line(input string name, input int x0, input int y0, input int x1,
                            input int y1, input int col, input int fe_at);
        int acc, nb, j, ea, ee;
        bit ok;
        model_line(x0, y0, x1, y1);
        clear_writes();
        send_cmd(x0, y0, x1, y1, col, acc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
        end
        nb = 0;
        forever begin
            @(negedge clk);
            frame_end = 1'b0;
            if (busy !== 1'b1 || nb > 2000) break;
            nb++;
            if (nb == fe_at) frame_end = 1'b1;
        end
        frame_end = 1'b0;
        n_cmp++;
        if (nb != ex_x.size() + 1) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, nb, ex_x.size() + 1);
        end
        j = 0;
        foreach (ex_x[i]) begin
            if (ex_x[i] < 320 && ex_y[i] < 240) begin
                ea = ex_y[i] + 240 * ex_x[i];
                ee = acc + 2 + i;
                n_cmp++;
                if (j >= wr_addr.size()) begin
                    n_bad++;
                    $display("FAIL %s write%0d: missing, required addr %0d din %0d edge %0d",
                             name, j, ea, col, ee);
                end else if (wr_addr[j] != ea || wr_din[j] != col || wr_edge[j] != ee) begin
                    n_bad++;
                    $display("FAIL %s write%0d: got addr %0d din %0d edge %0d required %0d %0d %0d",
                             name, j, wr_addr[j], wr_din[j], wr_edge[j], ea, col, ee);
                end
                j++;
            end
        end
        n_cmp++;
        if (wr_addr.size() != j) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), j);
        end
    endtask

    // After a swap: either a full zero clear or no writes at all
    task automatic wait_clear(input string name);
`ifdef LINE_RASTER_CLEAR_EN
        int g = 0;
        int bad_i = -1;
        while (busy === 1'b1 && g < 80000) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (wr_addr.size() != 76800) begin
            n_bad++;
            $display("FAIL %s clear_count: got %0d required 76800", name, wr_addr.size());
        end
        foreach (wr_addr[i]) begin
            if (bad_i < 0 && (wr_addr[i] != i || wr_din[i] != 0 || wr_edge[i] != wr_edge[0] + i))
                bad_i = i;
        end
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL %s clear_data: index %0d got addr %0d din %0d required addr %0d din 0",
                     name, bad_i, wr_addr[bad_i], wr_din[bad_i], bad_i);
        end
`else
        @(negedge clk);
        n_cmp++;
        if (wr_addr.size() != 0) begin
            n_bad++;
            $display("FAIL %s writes_after_swap: got %0d required 0", name, wr_addr.size());
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, done, busy, bb_we} !== 4'b0000 || waddr !== 17'd0 || din !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b done=%b busy=%b we=%b waddr=%0d din=%0d required all 0",
                     cmd_ready, done, busy, bb_we, waddr, din);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_early: cmd_ready=%b required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        run_line("horiz", 0, 0, 3, 0, 5, -1);
        run_line("diag", 0, 0, 2, 2, 1, -1);
        run_line("diag_rev", 2, 2, 0, 0, 1, -1);
        run_line("clip", 318, 0, 321, 0, 7, -1);
        n_cmp++;
        if (wr_addr.size() != 2 || wr_addr[0] != 76320 || wr_addr[1] != 76560) begin
            n_bad++;
            $display("FAIL clip_addrs: got %0d writes required 2 writes at 76320,76560",
                     wr_addr.size());
        end
        // swap outside DONE must have no effect
        swap = 1'b1;
        run_line("point", 10, 10, 10, 10, 4, -1);
        swap = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_ignored: done=%b cmd_ready=%b required 0 1", done, cmd_ready);
        end
    endtask

    task automatic test_random();
        int x0, y0, x1, y1;
        for (int k = 0; k < 30; k++) begin
            x0 = $urandom_range(0, 511);
            y0 = $urandom_range(0, 255);
            if (k % 2 == 0) begin
                x1 = $urandom_range(0, 511);
                y1 = $urandom_range(0, 255);
            end else begin
                x1 = (x0 + $urandom_range(0, 40)) % 512;
                y1 = (y0 + 256 - $urandom_range(0, 40)) % 256;
            end
            run_line($sformatf("rand%0d", k), x0, y0, x1, y1, $urandom_range(0, NCOL - 1), -1);
        end
    endtask

    task automatic test_frame_end();
        int g = 0;
        run_line("frame_line", 0, 5, 9, 5, 3, 4);
        while (done !== 1'b1 && g < 4) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_done: done=%b required 1", done);
        end
        clear_writes();
        // a second frame_end while in DONE is dropped
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || bb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_hold: done=%b ready=%b we=%b required 1 0 0",
                     done, cmd_ready, bb_we);
        end
        swap = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_swap: done=%b required 0", done);
        end
        @(negedge clk);
        swap = 1'b0;
        wait_clear("frame");
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_reopen: ready=%b done=%b required 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_same_cycle();
        int g = 0;
        bit leak = 1'b0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        clear_writes();
        cmd_x0    = 9'd5;
        cmd_y0    = 8'd5;
        cmd_x1    = 9'd8;
        cmd_y1    = 8'd8;
        cmd_color = 5'd2;
        cmd_valid = 1'b1;
        frame_end = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL same_ready: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge clk);
        frame_end = 1'b0;
        g = 0;
        while (done !== 1'b1 && g < 4) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL same_done: done=%b required 1", done);
        end
        repeat (4) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || done !== 1'b1) leak = 1'b1;
        end
        n_cmp++;
        if (leak) begin
            n_bad++;
            $display("FAIL same_blocked: ready/done left 0/1 while in DONE, got %b/%b",
                     cmd_ready, done);
        end
        n_cmp++;
        if (wr_addr.size() != 0) begin
            n_bad++;
            $display("FAIL same_nowrite: got %0d writes required 0", wr_addr.size());
        end
        cmd_valid = 1'b0;
        swap = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL same_swap: done=%b required 0", done);
        end
        @(negedge clk);
        swap = 1'b0;
        wait_clear("same");
    endtask

    task automatic test_reset_midline();
        int acc;
        bit ok;
        clear_writes();
        send_cmd(0, 0, 7, 0, 6, acc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL midrst_accept: cmd_ready=%b required 1", cmd_ready);
        end
        // third pixel is presented after edge acc+3
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bb_we, busy, cmd_ready, done} !== 4'b0000 || waddr !== 17'd0 || din !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: we=%b busy=%b ready=%b done=%b waddr=%0d din=%0d required 0",
                     bb_we, busy, cmd_ready, done, waddr, din);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: cmd_ready=%b required 1", cmd_ready);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() != 2 || wr_addr[0] != 0 || wr_addr[1] != 240) begin
            n_bad++;
            $display("FAIL midrst_writes: got %0d writes required 2 at 0,240", wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_frame_end();
        test_same_cycle();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
